// File: rtl/aes_selftest_pkg.sv
// Shared types and constants for the AES self-test sequencer: FSM states,
// key-size codes, SPI frame field offsets and the ROM entry layout.
package aes_selftest_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND_ENC,
    ST_WAIT_ENC,
    ST_REC_ENC,
    ST_CHECK_ENC,
    ST_SEND_DEC,
    ST_WAIT_DEC,
    ST_REC_DEC,
    ST_CHECK_DEC,
    ST_NEXT,
    ST_FINISH
  } state_e;

  localparam logic [7:0] SIZE_128 = 8'd16;
  localparam logic [7:0] SIZE_192 = 8'd24;
  localparam logic [7:0] SIZE_256 = 8'd32;

  // Outgoing frame is {block[127:0], key_size[7:0], key[255:0]};
  // the core returns its result block in RES_MSB:RES_LSB of the received frame.
  localparam int BLK_MSB = 391;
  localparam int KSZ_LSB = 256;
  localparam int RES_MSB = 383;
  localparam int RES_LSB = 256;

  typedef struct packed {
    logic [127:0] pt;
    logic [7:0]   key_size;
    logic [255:0] key;
    logic [127:0] ct;
  } vector_t;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/aes_selftest_rom.sv
// Known-answer vector table (FIPS-197 C.1/C.2/C.3); indices beyond 2 repeat
// modulo 3 so any NUM_VECTORS walks the three key sizes in turn.
import aes_selftest_pkg::*;

module aes_selftest_rom (
  input  logic [7:0] vec_idx,
  output vector_t    entry
);

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;

  logic [7:0] sel;

  always_comb begin
    sel            = vec_idx % 8'd3;
    entry          = '0;
    entry.pt       = PT_FIPS;
    case (sel)
      8'd0: begin
        entry.key_size = SIZE_128;
        entry.key      = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        entry.ct       = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      end
      8'd1: begin
        entry.key_size = SIZE_192;
        entry.key      = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        entry.ct       = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      end
      default: begin
        entry.key_size = SIZE_256;
        entry.key      = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        entry.ct       = 128'h8ea2b7ca516745bfeafc49904b496089;
      end
    endcase
  end

endmodule

// File: rtl/aes_selftest_seq.sv
// Built-in self-test sequencer: round-trips ROM vectors through the SPI AES core.
// Define AES_SELFTEST_TIMEOUT_EN to enable the per-transfer watchdog.
import aes_selftest_pkg::*;

module aes_selftest_seq #(
  parameter int NUM_VECTORS    = 3,
  parameter int FRAME_W        = 392,
  parameter int ENC_WAIT_XFERS = 1,
  parameter int DEC_WAIT_XFERS = 2,
  parameter int STOP_ON_FAIL   = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_system,
  output logic               xfer_start,
  input  logic               xfer_busy,
  input  logic               xfer_done,
  output logic [FRAME_W-1:0] xfer_tx,
  input  logic [FRAME_W-1:0] xfer_rx,
  output logic               busy,
  output logic               done,
  output logic               led,
  output logic [7:0]         pass_count,
  output logic [7:0]         fail_count,
  output logic [7:0]         fail_index,
  output logic               timeout
);

  // Transfer handshake: xfer_start is a one-cycle pulse issued only while the
  // master reports xfer_busy=0; the transfer is complete on the xfer_done pulse,
  // and xfer_done is ignored unless this sequencer has a transfer outstanding.

  state_e             state_q, state_d;
  logic [7:0]         vec_idx_q, vec_idx_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;
  logic               launched_q, launched_d;
  logic               vec_fail_q, vec_fail_d;
  logic               xfer_start_q, xfer_start_d;
  logic [FRAME_W-1:0] xfer_tx_q, xfer_tx_d;
  logic [127:0]       res_q, res_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               led_q, led_d;
  logic [7:0]         pass_q, pass_d;
  logic [7:0]         fail_q, fail_d;
  logic [7:0]         fidx_q, fidx_d;
  logic               timeout_q, timeout_d;

  vector_t            rom_entry;
  logic               is_xfer;
  logic               xfer_wait;
  logic               xfer_ok;
  logic               tmo_expire;
  logic               unused_rx;

  aes_selftest_rom u_rom (
    .vec_idx (vec_idx_q),
    .entry   (rom_entry)
  );

  assign is_xfer   = (state_q == ST_SEND_ENC) || (state_q == ST_WAIT_ENC) ||
                     (state_q == ST_REC_ENC)  || (state_q == ST_SEND_DEC) ||
                     (state_q == ST_WAIT_DEC) || (state_q == ST_REC_DEC);
  assign xfer_wait = is_xfer && launched_q;
  assign xfer_ok   = xfer_wait && xfer_done;
  assign unused_rx = ^{xfer_rx[FRAME_W-1:RES_MSB+1], xfer_rx[RES_LSB-1:0]};

`ifdef AES_SELFTEST_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  // A done arriving in the expiry cycle completes the transfer normally.
  assign tmo_expire = xfer_wait && !xfer_done &&
                      (tmo_cnt_q == 32'(TIMEOUT_CYCLES - 1));
  assign timeout    = timeout_q;
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign tmo_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    vec_idx_d    = vec_idx_q;
    wait_cnt_d   = wait_cnt_q;
    launched_d   = launched_q;
    vec_fail_d   = vec_fail_q;
    xfer_start_d = 1'b0;
    xfer_tx_d    = xfer_tx_q;
    res_d        = res_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    led_d        = led_q;
    pass_d       = pass_q;
    fail_d       = fail_q;
    fidx_d       = fidx_q;
    timeout_d    = timeout_q;

    if (is_xfer && !launched_q && !xfer_busy) begin
      xfer_start_d = 1'b1;
      launched_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (start_system) begin
          busy_d    = 1'b1;
          led_d     = 1'b0;
          pass_d    = 8'd0;
          fail_d    = 8'd0;
          fidx_d    = 8'hFF;
          timeout_d = 1'b0;
          vec_idx_d = 8'd0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        xfer_tx_d  = FRAME_W'({rom_entry.pt, rom_entry.key_size, rom_entry.key});
        vec_fail_d = 1'b0;
        launched_d = 1'b0;
        state_d    = ST_SEND_ENC;
      end
      ST_SEND_ENC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = (ENC_WAIT_XFERS > 0) ? ST_WAIT_ENC : ST_REC_ENC;
        end
      end
      ST_WAIT_ENC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          if (wait_cnt_q == 8'(ENC_WAIT_XFERS - 1)) state_d = ST_REC_ENC;
          else wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_REC_ENC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          res_d      = xfer_rx[RES_MSB:RES_LSB];
          state_d    = ST_CHECK_ENC;
        end
      end
      ST_CHECK_ENC: begin
        if (res_q != rom_entry.ct) begin
          fail_d     = sat_inc(fail_q);
          vec_fail_d = 1'b1;
          if (fidx_q == 8'hFF) fidx_d = vec_idx_q;
        end
        // Decrypt whatever came back, so a bad ciphertext also fails decrypt.
        xfer_tx_d = FRAME_W'({res_q, rom_entry.key_size, rom_entry.key});
        state_d   = ST_SEND_DEC;
      end
      ST_SEND_DEC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = (DEC_WAIT_XFERS > 0) ? ST_WAIT_DEC : ST_REC_DEC;
        end
      end
      ST_WAIT_DEC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          if (wait_cnt_q == 8'(DEC_WAIT_XFERS - 1)) state_d = ST_REC_DEC;
          else wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_REC_DEC: begin
        if (xfer_ok) begin
          launched_d = 1'b0;
          res_d      = xfer_rx[RES_MSB:RES_LSB];
          state_d    = ST_CHECK_DEC;
        end
      end
      ST_CHECK_DEC: begin
        if (res_q != rom_entry.pt) begin
          fail_d     = sat_inc(fail_q);
          vec_fail_d = 1'b1;
          if (fidx_q == 8'hFF) fidx_d = vec_idx_q;
        end else if (!vec_fail_q) begin
          pass_d = sat_inc(pass_q);
        end
        state_d = ST_NEXT;
      end
      ST_NEXT: begin
        if ((vec_idx_q == 8'(NUM_VECTORS - 1)) || ((STOP_ON_FAIL != 0) && vec_fail_q)) begin
          state_d = ST_FINISH;
        end else begin
          vec_idx_d = vec_idx_q + 8'd1;
          state_d   = ST_LOAD;
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        led_d   = (fail_q == 8'd0) && !timeout_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_expire) begin
      timeout_d  = 1'b1;
      launched_d = 1'b0;
      if (fidx_q == 8'hFF) fidx_d = vec_idx_q;
      state_d    = ST_FINISH;
    end

`ifdef AES_SELFTEST_TIMEOUT_EN
    tmo_cnt_d = tmo_cnt_q;
    if (xfer_start_d) tmo_cnt_d = 32'd0;
    else if (xfer_wait && (tmo_cnt_q != 32'(TIMEOUT_CYCLES - 1))) tmo_cnt_d = tmo_cnt_q + 32'd1;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      vec_idx_q    <= 8'd0;
      wait_cnt_q   <= 8'd0;
      launched_q   <= 1'b0;
      vec_fail_q   <= 1'b0;
      xfer_start_q <= 1'b0;
      xfer_tx_q    <= '0;
      res_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      led_q        <= 1'b0;
      pass_q       <= 8'd0;
      fail_q       <= 8'd0;
      fidx_q       <= 8'hFF;
      timeout_q    <= 1'b0;
`ifdef AES_SELFTEST_TIMEOUT_EN
      tmo_cnt_q    <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      vec_idx_q    <= vec_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      launched_q   <= launched_d;
      vec_fail_q   <= vec_fail_d;
      xfer_start_q <= xfer_start_d;
      xfer_tx_q    <= xfer_tx_d;
      res_q        <= res_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      led_q        <= led_d;
      pass_q       <= pass_d;
      fail_q       <= fail_d;
      fidx_q       <= fidx_d;
      timeout_q    <= timeout_d;
`ifdef AES_SELFTEST_TIMEOUT_EN
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

  assign xfer_start = xfer_start_q;
  assign xfer_tx    = xfer_tx_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign led        = led_q;
  assign pass_count = pass_q;
  assign fail_count = fail_q;
  assign fail_index = fidx_q;

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Bench for aes_selftest_seq: two DUTs (STOP_ON_FAIL 0 and 1), each driven by a
// behavioural SPI master + AES core answering from the FIPS-197 known answers.
module tb_aes_selftest_seq;

  localparam int FRAME_W = 392;

  localparam logic [127:0] TV_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] TV_CT [3] = '{
    128'h69c4e0d86a7b0430d8cdb78070b4c55a,
    128'hdda97ca4864cdfe06eaf70a0ec0d7191,
    128'h8ea2b7ca516745bfeafc49904b496089
  };
  localparam logic [7:0] TV_KSZ [3] = '{8'd16, 8'd24, 8'd32};
  localparam logic [255:0] TV_KEY [3] = '{
    256'h000102030405060708090a0b0c0d0e0f_00000000000000000000000000000000,
    256'h000102030405060708090a0b0c0d0e0f1011121314151617_0000000000000000,
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
  };

  logic               clk;
  logic               reset;
  logic               start_sys    [2];
  logic               xfer_start_w [2];
  logic               xfer_busy_w  [2];
  logic               xfer_done_w  [2];
  logic [FRAME_W-1:0] xfer_tx_w    [2];
  logic [FRAME_W-1:0] xfer_rx_w    [2];
  logic               busy_w       [2];
  logic               done_w       [2];
  logic               led_w        [2];
  logic [7:0]         pass_w       [2];
  logic [7:0]         fail_w       [2];
  logic [7:0]         fidx_w       [2];
  logic               tmo_w        [2];

  logic               corrupt      [2];
  logic               hang         [2];
  int                 mdl_cnt      [2];
  logic [FRAME_W-1:0] mdl_frame    [2];
  logic               clr_cnt;
  int                 nstart       [2];
  int                 ndone        [2];

  int n_vec;
  int n_miss;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    aes_selftest_seq #(
      .STOP_ON_FAIL   (g),
      .TIMEOUT_CYCLES (64)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .start_system (start_sys[g]),
      .xfer_start   (xfer_start_w[g]),
      .xfer_busy    (xfer_busy_w[g]),
      .xfer_done    (xfer_done_w[g]),
      .xfer_tx      (xfer_tx_w[g]),
      .xfer_rx      (xfer_rx_w[g]),
      .busy         (busy_w[g]),
      .done         (done_w[g]),
      .led          (led_w[g]),
      .pass_count   (pass_w[g]),
      .fail_count   (fail_w[g]),
      .fail_index   (fidx_w[g]),
      .timeout      (tmo_w[g])
    );
  end

  // ---------------- golden SPI master + AES core ----------------
  function automatic logic [FRAME_W-1:0] respond(input logic [FRAME_W-1:0] f, input logic bad);
    logic [127:0]       blk;
    logic [127:0]       res;
    logic [FRAME_W-1:0] r;
    blk = f[391:264];
    res = ~blk;
    for (int i = 0; i < 3; i++) begin
      if (f[263:256] == TV_KSZ[i] && f[255:0] == TV_KEY[i]) begin
        if (blk == TV_PT) res = TV_CT[i] ^ ((bad && i == 1) ? 128'h1 : 128'h0);
        else if (blk == TV_CT[i]) res = TV_PT;
      end
    end
    r = '0;
    r[391:384] = 8'hA5;
    r[383:256] = res;
    r[255:0]   = ~f[255:0];
    return r;
  endfunction

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (reset) begin
        xfer_busy_w[g] <= 1'b0;
        xfer_done_w[g] <= 1'b0;
        xfer_rx_w[g]   <= '0;
        mdl_cnt[g]     <= 0;
        mdl_frame[g]   <= '0;
      end else begin
        xfer_done_w[g] <= 1'b0;
        if (xfer_start_w[g]) begin
          xfer_busy_w[g] <= 1'b1;
          mdl_cnt[g]     <= 4;
          mdl_frame[g]   <= xfer_tx_w[g];
        end else if (xfer_busy_w[g] && !hang[g]) begin
          if (mdl_cnt[g] == 1) begin
            xfer_busy_w[g] <= 1'b0;
            xfer_done_w[g] <= 1'b1;
            xfer_rx_w[g]   <= respond(mdl_frame[g], corrupt[g]);
          end
          mdl_cnt[g] <= mdl_cnt[g] - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (clr_cnt) begin
        nstart[g] <= 0;
        ndone[g]  <= 0;
      end else begin
        if (xfer_start_w[g]) nstart[g] <= nstart[g] + 1;
        if (done_w[g])       ndone[g]  <= ndone[g] + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_counts();
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
  endtask

  task automatic pulse_start(input int g);
    @(negedge clk);
    start_sys[g] = 1'b1;
    @(negedge clk);
    start_sys[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_w[g]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        n_vec++;
        if (xfer_start_w[g] !== 1'b0) begin
          n_miss++; $display("FAIL reset_xfer_start dut%0d: got %b want 0", g, xfer_start_w[g]);
        end
      end
    end
    for (int g = 0; g < 2; g++) begin
      n_vec++;
      if (busy_w[g] !== 1'b0 || done_w[g] !== 1'b0 || led_w[g] !== 1'b0 || tmo_w[g] !== 1'b0) begin
        n_miss++; $display("FAIL reset_flags dut%0d: busy=%b done=%b led=%b tmo=%b want 0000",
                           g, busy_w[g], done_w[g], led_w[g], tmo_w[g]);
      end
      n_vec++;
      if (pass_w[g] !== 8'd0 || fail_w[g] !== 8'd0 || fidx_w[g] !== 8'hFF) begin
        n_miss++; $display("FAIL reset_counts dut%0d: pass=%0d fail=%0d idx=%h want 0 0 ff",
                           g, pass_w[g], fail_w[g], fidx_w[g]);
      end
      n_vec++;
      if (xfer_tx_w[g] !== '0) begin
        n_miss++; $display("FAIL reset_xfer_tx dut%0d: got %h want 0", g, xfer_tx_w[g]);
      end
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_pass();
    bit ok;
    corrupt[0] = 1'b0;
    clear_counts();
    pulse_start(0);
    wait_done(0, 2000, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL pass_done: done=0 want 1 within budget"); end
    n_vec++;
    if (pass_w[0] !== 8'd3) begin n_miss++; $display("FAIL pass_pass_count: got %0d want 3", pass_w[0]); end
    n_vec++;
    if (fail_w[0] !== 8'd0) begin n_miss++; $display("FAIL pass_fail_count: got %0d want 0", fail_w[0]); end
    n_vec++;
    if (fidx_w[0] !== 8'hFF) begin n_miss++; $display("FAIL pass_fail_index: got %h want ff", fidx_w[0]); end
    n_vec++;
    if (led_w[0] !== 1'b1) begin n_miss++; $display("FAIL pass_led: got %b want 1", led_w[0]); end
    n_vec++;
    if (busy_w[0] !== 1'b0) begin n_miss++; $display("FAIL pass_busy_fall: got %b want 0", busy_w[0]); end
    repeat (4) @(negedge clk);
    n_vec++;
    if (nstart[0] !== 21) begin n_miss++; $display("FAIL pass_xfer_count: got %0d want 21", nstart[0]); end
    n_vec++;
    if (ndone[0] !== 1) begin n_miss++; $display("FAIL pass_done_pulses: got %0d want 1", ndone[0]); end
  endtask

  task automatic test_fail_continue();
    bit ok;
    corrupt[0] = 1'b1;
    clear_counts();
    pulse_start(0);
    wait_done(0, 2000, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL corrupt_done: done=0 want 1 within budget"); end
    n_vec++;
    if (fail_w[0] !== 8'd2) begin n_miss++; $display("FAIL corrupt_fail_count: got %0d want 2", fail_w[0]); end
    n_vec++;
    if (pass_w[0] !== 8'd2) begin n_miss++; $display("FAIL corrupt_pass_count: got %0d want 2", pass_w[0]); end
    n_vec++;
    if (fidx_w[0] !== 8'd1) begin n_miss++; $display("FAIL corrupt_fail_index: got %h want 01", fidx_w[0]); end
    n_vec++;
    if (led_w[0] !== 1'b0) begin n_miss++; $display("FAIL corrupt_led: got %b want 0", led_w[0]); end
    @(negedge clk);
    n_vec++;
    if (nstart[0] !== 21) begin n_miss++; $display("FAIL corrupt_xfer_count: got %0d want 21", nstart[0]); end
    corrupt[0] = 1'b0;
  endtask

  task automatic test_stop_on_fail();
    bit ok;
    corrupt[1] = 1'b1;
    clear_counts();
    pulse_start(1);
    wait_done(1, 2000, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL stop_done: done=0 want 1 within budget"); end
    @(negedge clk);
    n_vec++;
    if (nstart[1] !== 14) begin n_miss++; $display("FAIL stop_xfer_count: got %0d want 14", nstart[1]); end
    n_vec++;
    if (pass_w[1] !== 8'd1) begin n_miss++; $display("FAIL stop_pass_count: got %0d want 1", pass_w[1]); end
    n_vec++;
    if (fail_w[1] !== 8'd2) begin n_miss++; $display("FAIL stop_fail_count: got %0d want 2", fail_w[1]); end
    n_vec++;
    if (fidx_w[1] !== 8'd1) begin n_miss++; $display("FAIL stop_fail_index: got %h want 01", fidx_w[1]); end
    n_vec++;
    if (led_w[1] !== 1'b0) begin n_miss++; $display("FAIL stop_led: got %b want 0", led_w[1]); end
    corrupt[1] = 1'b0;
  endtask

  task automatic test_busy_start();
    bit ok;
    clear_counts();
    pulse_start(0);
    repeat (20) @(negedge clk);
    pulse_start(0);
    repeat (40) @(negedge clk);
    pulse_start(0);
    wait_done(0, 2000, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL busy_start_done: done=0 want 1 within budget"); end
    n_vec++;
    if (pass_w[0] !== 8'd3) begin n_miss++; $display("FAIL busy_start_pass: got %0d want 3", pass_w[0]); end
    repeat (15) @(negedge clk);
    n_vec++;
    if (nstart[0] !== 21) begin n_miss++; $display("FAIL busy_start_xfers: got %0d want 21", nstart[0]); end
    n_vec++;
    if (ndone[0] !== 1 || busy_w[0] !== 1'b0) begin
      n_miss++; $display("FAIL busy_start_rerun: done_pulses=%0d busy=%b want 1 0", ndone[0], busy_w[0]);
    end
  endtask

  task automatic test_reset_midrun();
    bit reached;
    clear_counts();
    pulse_start(0);
    reached = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (nstart[0] >= 5) begin
        reached = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!reached) begin n_miss++; $display("FAIL midrun_reach_wait_dec: xfers=%0d want 5", nstart[0]); end
    reset = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy_w[0] !== 1'b0 || xfer_start_w[0] !== 1'b0 || done_w[0] !== 1'b0 || led_w[0] !== 1'b0) begin
      n_miss++; $display("FAIL midrun_flags: busy=%b start=%b done=%b led=%b want 0000",
                         busy_w[0], xfer_start_w[0], done_w[0], led_w[0]);
    end
    n_vec++;
    if (pass_w[0] !== 8'd0 || fail_w[0] !== 8'd0 || fidx_w[0] !== 8'hFF || xfer_tx_w[0] !== '0) begin
      n_miss++; $display("FAIL midrun_counts: pass=%0d fail=%0d idx=%h tx_nonzero=%b want 0 0 ff 0",
                         pass_w[0], fail_w[0], fidx_w[0], xfer_tx_w[0] != '0);
    end
    reset = 1'b0;
    clear_counts();
    repeat (30) @(negedge clk);
    n_vec++;
    if (nstart[0] !== 0 || busy_w[0] !== 1'b0) begin
      n_miss++; $display("FAIL midrun_quiet: xfers=%0d busy=%b want 0 0", nstart[0], busy_w[0]);
    end
  endtask

`ifdef AES_SELFTEST_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    int k;
    hang[0] = 1'b1;
    clear_counts();
    pulse_start(0);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (xfer_start_w[0]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL tmo_first_start: xfer_start=0 want 1"); end
    k = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      k++;
      if (tmo_w[0]) break;
    end
    n_vec++;
    if (k !== 64 || tmo_w[0] !== 1'b1) begin
      n_miss++; $display("FAIL tmo_latency: cycles=%0d timeout=%b want 64 1", k, tmo_w[0]);
    end
    wait_done(0, 10, ok);
    n_vec++;
    if (!ok) begin n_miss++; $display("FAIL tmo_done: done=0 want 1"); end
    n_vec++;
    if (led_w[0] !== 1'b0 || fidx_w[0] !== 8'd0) begin
      n_miss++; $display("FAIL tmo_result: led=%b idx=%h want 0 00", led_w[0], fidx_w[0]);
    end
    reset = 1'b1;
    hang[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    n_vec   = 0;
    n_miss  = 0;
    reset   = 1'b1;
    clr_cnt = 1'b0;
    for (int g = 0; g < 2; g++) begin
      start_sys[g] = 1'b0;
      corrupt[g]   = 1'b0;
      hang[g]      = 1'b0;
    end
    test_reset();
    test_all_pass();
    test_fail_continue();
    test_stop_on_fail();
    test_busy_start();
    test_reset_midrun();
`ifdef AES_SELFTEST_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/aes_selftest_seq.md
# aes_selftest_seq

Parametrised built-in self-test sequencer for the SPI-attached AES core. It replaces the single-vector encrypt/decrypt wrapper. It walks a table of NUM_VECTORS test vectors covering 128/192/256-bit keys, drives the full-duplex SPI master transaction engine, and round-trips each vector through encryption and decryption. It sits between the board-level start/LED pins and the SPI master, and reports per-run pass/fail counts and the first failing vector.

## Interface
Parameters:
- NUM_VECTORS, 3: vectors run per test; 1..255.
- FRAME_W, 392: SPI frame width; {block[127:0], key_size[7:0], key[255:0]}.
- ENC_WAIT_XFERS, 1: dummy transfers between the encrypt send and the encrypt receive.
- DEC_WAIT_XFERS, 2: dummy transfers between the decrypt send and the decrypt receive.
- STOP_ON_FAIL, 0: 1 = end the run at the first failing check.
- TIMEOUT_CYCLES, 4096: watchdog limit per transfer (used only with the macro).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start_system  in  1  run request; sampled only in IDLE.
- xfer_start  out  1  one-cycle pulse that launches an SPI transfer.
- xfer_busy  in  1  master busy.
- xfer_done  in  1  one-cycle pulse at transfer end.
- xfer_tx  out  FRAME_W  frame to send.
- xfer_rx  in  FRAME_W  frame received; result block in [383:256].
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- led  out  1  1 = last run fully passed.
- pass_count  out  8  vectors passing both checks.
- fail_count  out  8  failing checks (encrypt and decrypt counted separately).
- fail_index  out  8  index of the first failing vector; 8'hFF if none.
- timeout  out  1  sticky watchdog flag (macro only; otherwise tied 0).

## Operation
- States: IDLE, LOAD, SEND_ENC, WAIT_ENC, REC_ENC, CHECK_ENC, SEND_DEC, WAIT_DEC, REC_DEC, CHECK_DEC, NEXT, FINISH.
- IDLE → LOAD when start_system=1. The run clears the counters, sets fail_index=FF and vec_idx=0.
- LOAD: xfer_tx={pt, key_size, key} from the ROM entry at vec_idx. key_size is 16/24/32. The key is left-aligned and zero-padded to 256 bits.
- Each SEND/WAIT/REC state:
  - Pulses xfer_start once when xfer_busy=0.
  - Then holds until xfer_done. One transfer per pulse.
  - WAIT_x repeats for *_WAIT_XFERS transfers using a wait counter.
- REC_x latches xfer_rx[383:256] into res_q on xfer_done.
- CHECK_ENC compares res_q against the expected ciphertext:
  - Mismatch: fail_count+1 and record fail_index.
  - Then xfer_tx={res_q, key_size, key}.
- CHECK_DEC compares res_q against the plaintext with the same fail handling. A vector whose encrypt and decrypt checks both pass increments pass_count.
- NEXT:
  - vec_idx==NUM_VECTORS-1 → FINISH; otherwise vec_idx+1 → LOAD. No wrap.
  - With STOP_ON_FAIL=1, any failure in the current vector → FINISH.
- FINISH: done=1 for one cycle, led=(fail_count==0 && !timeout), → IDLE. led, counts and fail_index hold until the next run starts.
- Ignored conditions:
  - start_system while busy.
  - xfer_done outside SEND/WAIT/REC states.
- Counters saturate at 255.

## Timing
- Reset values: xfer_start=0, xfer_tx=0, busy=0, done=0, led=0, pass_count=0, fail_count=0, fail_index=FF, timeout=0, state=IDLE.
- All outputs are registered.
- xfer_start rises the cycle after entering a transfer state, or the first cycle after that in which xfer_busy=0.
- xfer_tx is stable from LOAD/CHECK_ENC until the next LOAD.
- Every state transition takes one cycle. CHECK_x and NEXT take one cycle each.
- Transfers per vector: 2+ENC_WAIT_XFERS+2+DEC_WAIT_XFERS (7 at defaults).
- busy rises the cycle after start_system is sampled and falls with the done pulse.
- Reset mid-run: IDLE on the next edge, no further xfer_start, outputs at reset values. The master shares the same reset.

## Configuration
- AES_SELFTEST_TIMEOUT_EN defined:
  - A per-transfer cycle counter starts at xfer_start.
  - If it reaches TIMEOUT_CYCLES without xfer_done: timeout=1, fail_index=vec_idx if still FF, → FINISH.
  - If xfer_done and expiry occur in the same cycle, xfer_done wins.
- Not defined: no counter, timeout tied 0, transfers wait indefinitely.

## Structure
- Shared package aes_selftest_pkg holds:
  - The state enum.
  - SIZE_128/192/256 constants.
  - Frame field offsets: BLK_MSB=391, KSZ_LSB=256, RES_MSB=383.
- Sub-module aes_selftest_rom: combinational lookup by vec_idx returning {pt, key_size, key, ct}.
  - Entry 0: FIPS-197 C.1, 128-bit key.
  - Entry 1: C.2, 192-bit key.
  - Entry 2: C.3, 256-bit key.
  - Entries beyond 2 repeat modulo 3.

## Test plan
- Reset held 5 cycles → all outputs at reset values, no xfer_start.
- Golden SPI/AES model, NUM_VECTORS=3, pulse start_system → 21 xfer_start pulses. Received ciphertexts are:
  - 69c4e0d86a7b0430d8cdb78070b4c55a
  - dda97ca4864cdfe06eaf70a0ec0d7191
  - 8ea2b7ca516745bfeafc49904b496089

  Expected result: pass_count=3, fail_count=0, fail_index=FF, led=1, one done pulse.
- Model corrupts the ciphertext of vector 1, STOP_ON_FAIL=0 → fail_count=2 (the decrypt check also fails), pass_count=2, fail_index=1, led=0.
- Same corruption with STOP_ON_FAIL=1 → done after 14 transfers, pass_count=1, fail_index=1.
- Macro defined, TIMEOUT_CYCLES=64, model never returns xfer_done → timeout=1 exactly 64 cycles after xfer_start, done pulse, led=0, fail_index=0.
- Assert reset during WAIT_DEC, and separately pulse start_system while busy → IDLE next edge with zeroed outputs; the busy-time start_system is ignored with no extra transfers.
